// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake and operand/result bus
// of the digit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  ready, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output ready, done, s, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, least-significant digit
// first, one DIGIT-wide slice plus a carry register, start/done handshake.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus_if
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [DIGIT:0]   sum;
    logic             c_msb;

    // Operands shift right each digit, so the slice always reads bit 0.
    assign sum = {1'b0, a_q[DIGIT-1:0]}
               + {1'b0, b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};

    // Carry into the slice's top bit, recovered from that bit's sum.
    assign c_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum[DIGIT-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus_if.start) begin
                    a_d     = bus_if.a;
                    b_d     = bus_if.sub ? ~bus_if.b : bus_if.b;
                    carry_d = bus_if.sub | bus_if.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = sum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i)) begin
                        s_d[i*DIGIT +: DIGIT] = sum[DIGIT-1:0];
                    end
                end
                if (cnt_q == LAST) begin
                    cout_d  = sum[DIGIT];
                    ovf_d   = c_msb ^ sum[DIGIT];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus_if.ready = (state_q == IDLE);
    assign bus_if.done  = done_q;
    assign bus_if.s     = s_q;
    assign bus_if.cout  = cout_q;
    assign bus_if.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder
// against an integer-arithmetic reference model.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(8)) if8q ();
    serial_adder_if #(.WIDTH(4)) if4a ();
    serial_adder_if #(.WIDTH(4)) if4b ();
    serial_adder_if #(.WIDTH(4)) if4c ();

    logic [1:0] st8 = '0;
    logic       sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8v = '0;
    logic       st4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4v = '0;

    assign if8.start  = st8[0];
    assign if8q.start = st8[1];
    assign if8.sub  = sub8;  assign if8q.sub  = sub8;
    assign if8.cin  = cin8;  assign if8q.cin  = cin8;
    assign if8.a    = a8;    assign if8q.a    = a8;
    assign if8.b    = b8v;   assign if8q.b    = b8v;

    assign if4a.start = st4;  assign if4b.start = st4;  assign if4c.start = st4;
    assign if4a.sub   = sub4; assign if4b.sub   = sub4; assign if4c.sub   = sub4;
    assign if4a.cin   = cin4; assign if4b.cin   = cin4; assign if4c.cin   = cin4;
    assign if4a.a     = a4;   assign if4b.a     = a4;   assign if4c.a     = a4;
    assign if4a.b     = b4v;  assign if4b.b     = b4v;  assign if4c.b     = b4v;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .bus_if(if8));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u8q (
        .clk(clk), .rst_n(rst_n), .bus_if(if8q));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u4a (
        .clk(clk), .rst_n(rst_n), .bus_if(if4a));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u4b (
        .clk(clk), .rst_n(rst_n), .bus_if(if4b));
    serial_adder #(.WIDTH(4), .DIGIT(4)) u4c (
        .clk(clk), .rst_n(rst_n), .bus_if(if4c));

    // Result packed as {ovf, cout, s[7:0]} from plain integer arithmetic.
    function automatic int model(int w, int a, int b, bit ci, bit sb);
        int full, sa, sbv, r, half, m;
        bit co, ov;
        m    = 1 << w;
        half = 1 << (w - 1);
        full = sb ? a + (m - b) : a + b + int'(ci);
        co   = full >= m;
        sa   = (a >= half) ? a - m : a;
        sbv  = (b >= half) ? b - m : b;
        r    = sb ? sa - sbv : sa + sbv + int'(ci);
        ov   = (r < -half) || (r >= half);
        return (int'(ov) << 9) | (int'(co) << 8) | (full % m);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic done8(int sel);
        return (sel != 0) ? if8q.done : if8.done;
    endfunction

    function automatic logic rdy8(int sel);
        return (sel != 0) ? if8q.ready : if8.ready;
    endfunction

    function automatic int res8(int sel);
        if (sel != 0)
            return int'({if8q.ovf, if8q.cout, if8q.s});
        return int'({if8.ovf, if8.cout, if8.s});
    endfunction

    // Starts one op, scrambles inputs after acceptance, waits for done.
    task automatic run8(input int sel, input logic sb, input logic [7:0] aa,
                        input logic [7:0] bb, input logic ci,
                        output int lat, output int rdy_ok, output int res);
        st8[sel] = 1'b1;
        sub8 = sb; a8 = aa; b8v = bb; cin8 = ci;
        @(posedge clk); #1;
        st8[sel] = 1'b0;
        a8 = 8'($urandom); b8v = 8'($urandom);
        cin8 = 1'($urandom); sub8 = 1'($urandom);
        lat = -1;
        rdy_ok = rdy8(sel) ? 0 : 1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done8(sel)) begin
                lat = c;
                break;
            end
            if (rdy8(sel)) rdy_ok = 0;
        end
        res = res8(sel);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rdy_ok, res, nd, exp;
        logic sb, ci;
        logic [7:0] ra, rb;
        int la, lb, lc, qa, qb, qc;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(if8.ready), 1);
        chk("rst_done", int'(if8.done), 0);
        chk("rst_res", res8(0), 0);
        chk("rst_res_q", res8(1), 0);
        chk("rst_ready4", int'({if4a.ready, if4b.ready, if4c.ready}), 7);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run8(0, 1'b0, 8'hFF, 8'h01, 1'b0, lat, rdy_ok, res);
        chk("ff01_lat", lat, 8);
        chk("ff01_ready_low", rdy_ok, 1);
        chk("ff01_res", res, 'h100);
        chk("ff01_ready_done", int'(if8.ready), 1);
        @(posedge clk); #1;
        chk("ff01_done_pulse", int'(if8.done), 0);
        chk("ff01_hold", res8(0), 'h100);

        run8(0, 1'b0, 8'h7F, 8'h01, 1'b0, lat, rdy_ok, res);
        chk("7f01_res", res, 'h280);
        run8(0, 1'b1, 8'h05, 8'h07, 1'b0, lat, rdy_ok, res);
        chk("sub0507_res", res, 'h0FE);
        run8(0, 1'b1, 8'h80, 8'h01, 1'b1, lat, rdy_ok, res);
        chk("sub8001_res", res, 'h37F);

        run8(1, 1'b0, 8'hA5, 8'h5B, 1'b1, lat, rdy_ok, res);
        chk("d4_lat", lat, 2);
        chk("d4_res", res, 'h101);

        // start held high: ignored mid-run, re-accepted on the done cycle
        st8[0] = 1'b1;
        sub8 = 1'b0; a8 = 8'h12; b8v = 8'h34; cin8 = 1'b0;
        @(posedge clk); #1;
        sub8 = 1'b1; a8 = 8'h55; b8v = 8'h66; cin8 = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (if8.done) begin
                lat = c;
                break;
            end
        end
        chk("held_lat1", lat, 8);
        chk("held_res1", res8(0), model(8, 'h12, 'h34, 1'b0, 1'b0));
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) st8[0] = 1'b0;
            if (if8.done) begin
                lat = c;
                break;
            end
        end
        chk("held_lat2", lat, 9);
        chk("held_res2", res8(0), model(8, 'h55, 'h66, 1'b1, 1'b1));

        // reset in the middle of a run
        st8[0] = 1'b1;
        sub8 = 1'b0; a8 = 8'h11; b8v = 8'h22; cin8 = 1'b0;
        @(posedge clk); #1;
        st8[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rrun_ready", int'(if8.ready), 1);
        chk("rrun_done", int'(if8.done), 0);
        chk("rrun_res", res8(0), 0);
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (if8.done) nd++;
        end
        chk("rrun_no_done", nd, 0);
        run8(0, 1'b0, 8'h03, 8'h04, 1'b0, lat, rdy_ok, res);
        chk("rrun_0304", res, 'h007);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            sb = 1'($urandom); ci = 1'($urandom);
            run8(i % 2, sb, ra, rb, ci, lat, rdy_ok, res);
            chk($sformatf("rnd%0d_res", i), res, model(8, ra, rb, ci, sb));
            chk($sformatf("rnd%0d_lat", i), lat, (i % 2 != 0) ? 2 : 8);
        end

        for (int s_ = 0; s_ < 2; s_++)
        for (int c_ = 0; c_ < 2; c_++)
        for (int a_ = 0; a_ < 16; a_++)
        for (int b_ = 0; b_ < 16; b_++) begin
            st4 = 1'b1;
            sub4 = 1'(s_); cin4 = 1'(c_); a4 = 4'(a_); b4v = 4'(b_);
            @(posedge clk); #1;
            st4 = 1'b0;
            a4 = 4'($urandom); b4v = 4'($urandom);
            la = -1; lb = -1; lc = -1; qa = -1; qb = -1; qc = -1;
            for (int c = 1; c <= 4; c++) begin
                @(posedge clk); #1;
                if (if4a.done) begin
                    la = c; qa = int'({if4a.ovf, if4a.cout, 4'h0, if4a.s});
                end
                if (if4b.done) begin
                    lb = c; qb = int'({if4b.ovf, if4b.cout, 4'h0, if4b.s});
                end
                if (if4c.done) begin
                    lc = c; qc = int'({if4c.ovf, if4c.cout, 4'h0, if4c.s});
                end
            end
            exp = model(4, a_, b_, 1'(c_), 1'(s_));
            chk($sformatf("sw_d1 a=%0h b=%0h ci=%0d sub=%0d", a_, b_, c_, s_), qa, exp);
            chk($sformatf("sw_d2 a=%0h b=%0h ci=%0d sub=%0d", a_, b_, c_, s_), qb, exp);
            chk($sformatf("sw_d4 a=%0h b=%0h ci=%0d sub=%0d", a_, b_, c_, s_), qc, exp);
            chk("sw_lat_d1", la, 4);
            chk("sw_lat_d2", lb, 2);
            chk("sw_lat_d4", lc, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, least-significant digit first, through one DIGIT-wide adder slice and a carry register.
- Supports add and subtract modes and reports signed overflow.
- Uses a start/done handshake so the arithmetic datapath can trade area for latency.

Parameters:
- WIDTH, default 8: operand and sum width in bits. Must be ≥2.
- DIGIT, default 1: bits processed per cycle. Must divide WIDTH; DIGIT=WIDTH gives a single-cycle registered adder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new operation; accepted only when ready=1.
- sub  input  1  0: a+b+cin; 1: a+~b+1, with cin ignored.
- a  input  WIDTH  operand A, sampled at start acceptance.
- b  input  WIDTH  operand B, sampled at start acceptance.
- cin  input  1  carry-in, sampled at start acceptance.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse when s, cout and ovf become valid.
- s  output  WIDTH  sum.
- cout  output  1  carry-out of the MSB. In sub mode, cout=1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n). All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - state=IDLE, ready=1, done=0.
  - s=0, cout=0, ovf=0.
  - Internal operand, carry and counter registers cleared.
  - Reset wins over start and aborts any operation in progress, with no done pulse.
- States are IDLE and RUN. N = WIDTH/DIGIT.
- IDLE, start=1 at an edge:
  - Latch a, and b (or ~b if sub=1).
  - Carry register = cin (or 1 if sub=1).
  - Digit counter = 0. Go to RUN; ready=0.
  - s, cout and ovf keep their previous values until overwritten.
- IDLE, start=0: hold; done=0.
- RUN, each edge:
  - Add digit[counter] of A and B with the carry register.
  - Write the DIGIT result bits into s at bit position counter*DIGIT.
  - Update the carry register and increment the counter.
- RUN, edge processing digit N-1:
  - cout = carry out. ovf = carry into bit WIDTH-1 XOR carry out.
  - done=1 for exactly one cycle; state=IDLE, ready=1.
- Latency: start accepted at edge k gives done=1 after edge k+N. Final s, cout and ovf are valid from edge k+N and held until the next accepted start's result overwrites them.
- s is partially updated during RUN. Consumers must only sample on done.
- start while in RUN is ignored; it is neither queued nor does it corrupt the operation.
- start in the cycle where done=1: ready=1, so it is accepted. Back-to-back operations have a throughput of one per N+1 cycles.
- a, b, sub and cin may change freely after acceptance without affecting the result.
- Arithmetic is modulo 2^WIDTH on s. The full result is {cout, s}.

Test Plan:
- WIDTH=8, DIGIT=1, add 0xFF+0x01, cin=0 → after exactly 8 RUN cycles: done pulse, s=0x00, cout=1, ovf=0; ready low for the 8 cycles.
- WIDTH=8, DIGIT=1, add 0x7F+0x01 → s=0x80, cout=0, ovf=1. Then sub 0x05−0x07 → s=0xFE, cout=0, ovf=0. Then sub 0x80−0x01 → s=0x7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=4, add 0xA5+0x5B, cin=1 → done 2 cycles after acceptance, s=0x01, cout=1, ovf=0.
- start pulsed again mid-RUN with different operands → ignored; first result unchanged. start held high across done → second operation accepted on the done cycle, and its done follows N+1 cycles after the first done.
- rst_n=0 for one edge during RUN → no done pulse; ready=1, s=0, cout=0, ovf=0 next cycle. A subsequent 0x03+0x04 gives s=0x07.
- WIDTH=4, DIGIT in {1,2,4}: exhaustive sweep of all a, b, cin, sub combinations against a behavioural model of {cout,s} and ovf → zero mismatches.
